// File: rtl/nn_param_pkg.sv
// Shared definitions for the neuron parameter bank and its readback path.
// The byte-offset constants fix the order of the six bytes of one neuron so
// that the loader and the readback serializer agree on the frame layout.
package nn_param_pkg;

    localparam int NUM_NEURONS       = 4;
    localparam int PARAMS_PER_NEURON = 6;
    localparam int PARAM_W           = 8;
    localparam int NBYTES            = NUM_NEURONS * PARAMS_PER_NEURON;

    // Position of each parameter inside one neuron's group of bytes
    localparam int OFF_W0 = 0;
    localparam int OFF_W1 = 1;
    localparam int OFF_W2 = 2;
    localparam int OFF_W3 = 3;
    localparam int OFF_B  = 4;
    localparam int OFF_TH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

    // Flat byte index of a given parameter of a given neuron
    function automatic int param_byte_index(input int neuron, input int offset);
        return neuron * PARAMS_PER_NEURON + offset;
    endfunction

endpackage

// File: rtl/param_readback_serializer_if.sv
// Valid/ready byte stream carrying the readback frame towards the host link.
interface param_readback_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // Producer side: the serializer
    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    // Consumer side: the debug/host link
    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/param_readback_serializer.sv
// Readback transmitter for the neuron parameter bank. A start pulse freezes
// the whole bank into a snapshot, which is then streamed byte by byte over a
// valid/ready interface, optionally followed by an XOR checksum byte.
// All stream outputs come straight from registers.
module param_readback_serializer #(
    parameter int NUM_NEURONS       = nn_param_pkg::NUM_NEURONS,
    parameter int PARAMS_PER_NEURON = nn_param_pkg::PARAMS_PER_NEURON,
    parameter int DATA_W            = nn_param_pkg::PARAM_W,
    parameter bit CHECKSUM_EN       = 1'b1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [NUM_NEURONS*PARAMS_PER_NEURON*DATA_W-1:0] params_in,
    param_readback_serializer_if.master                   out_if,
    output logic                                          busy,
    output logic                                          done
);
    import nn_param_pkg::*;

    localparam int FRAME_BYTES = NUM_NEURONS * PARAMS_PER_NEURON;
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    // Running checksum step: the trailer is the XOR of every frame byte
    function automatic logic [DATA_W-1:0] xor_acc(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] data
    );
        return acc ^ data;
    endfunction

    state_t                               state_q, state_d;
    logic [FRAME_BYTES-1:0][DATA_W-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]                     index_q, index_d;
    logic [DATA_W-1:0]                    csum_q, csum_d;
    logic [DATA_W-1:0]                    data_q, data_d;
    logic                                 valid_q, valid_d;
    logic                                 last_q, last_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;

    logic                                 hs_s;
    logic [IDX_W-1:0]                     index_inc_s;
    logic [DATA_W-1:0]                    csum_next_s;

    assign hs_s        = valid_q & out_if.out_ready;
    assign index_inc_s = index_q + IDX_W'(1);
    assign csum_next_s = xor_acc(csum_q, data_q);

    // Next-state and next-output logic; everything holds unless changed below
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        index_d = index_q;
        csum_d  = csum_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // abort beats a coincident start, even though idle
                if (start && !abort) begin
                    snap_d  = params_in;
                    index_d = '0;
                    csum_d  = '0;
                    data_d  = params_in[DATA_W-1:0];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end

            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                    data_d  = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (hs_s) begin
                    csum_d = csum_next_s;
                    if (index_q != LAST_IDX) begin
                        index_d = index_inc_s;
                        data_d  = snap_q[index_inc_s];
                        last_d  = (index_inc_s == LAST_IDX) && !CHECKSUM_EN;
                    end else if (CHECKSUM_EN) begin
                        // the accumulated value already includes this last byte
                        state_d = CSUM;
                        data_d  = csum_next_s;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        data_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    // stalled by the sink: present the same byte again
                    state_d = SEND;
                end
            end

            CSUM: begin
                if (abort) begin
                    state_d = IDLE;
                    data_d  = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (hs_s) begin
                    state_d = IDLE;
                    data_d  = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = CSUM;
                end
            end

            default: begin
                state_d = IDLE;
                data_d  = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            index_q <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            index_q <= index_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: doc/param_readback_serializer.md
Name: param_readback_serializer

Overview:
Readback transmitter for the neuron parameter bank. On a start pulse it snapshots all parameter bytes from the bank's parallel outputs (4 neurons x {w0..w3, b, th}). It then streams them out one byte per handshake on a valid/ready byte interface, with an optional trailing XOR checksum byte. It sits between the parameter register bank and the debug/host link, so loaded weights can be verified end to end.

Parameters:
NUM_NEURONS, 4, number of neurons in the bank
PARAMS_PER_NEURON, 6, bytes per neuron (w0,w1,w2,w3,b,th)
DATA_W, 8, width of each parameter and of out_data
CHECKSUM_EN, 1, 1 = append XOR checksum byte after the last parameter; 0 = no trailer

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
start  input  1  single-cycle request to snapshot and send; honoured only when busy=0
abort  input  1  synchronous cancel; returns to IDLE next cycle, no done pulse
params_in  input  NUM_NEURONS*PARAMS_PER_NEURON*DATA_W  flat bank; byte k at [k*DATA_W +: DATA_W]; k = n*6 + {0:w_n0,1:w_n1,2:w_n2,3:w_n3,4:b_n,5:th_n}
out_data  output  DATA_W  current byte
out_valid  output  1  out_data is valid
out_ready  input  1  sink accepts the byte when out_valid&&out_ready
out_last  output  1  high with the final byte of the frame (checksum if enabled, else th of the last neuron)
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the final byte handshake

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports named clk and reset.
- Reset (reset=0): state=IDLE; out_data=0, out_valid=0, out_last=0, busy=0, done=0, index=0, csum=0, snapshot=0.
- NBYTES = NUM_NEURONS*PARAMS_PER_NEURON (24). Index counter width = $clog2(NBYTES).
- FSM states: IDLE, SEND, CSUM.
- IDLE: on start=1, capture params_in into the snapshot register, index=0, csum=0, go to SEND. busy=1 and out_valid=1 with byte 0 from the next cycle (1-cycle start latency).
- SEND: out_data=snapshot byte[index]; out_last = (index==NBYTES-1) && !CHECKSUM_EN.
  - On handshake: csum ^= out_data.
  - If index < NBYTES-1: index++.
  - Else: go to CSUM if CHECKSUM_EN, otherwise go to IDLE with done=1.
  - Without a handshake, out_data, out_valid and out_last hold stable (standard valid/ready: valid never drops before acceptance).
- CSUM: out_data = csum (XOR of all NBYTES bytes), out_valid=1, out_last=1. On handshake, go to IDLE with done=1.
- done: registered 1-cycle pulse in the cycle after the final handshake. busy and out_valid are 0 in that same cycle.
- Start during busy=1 is ignored, with no queuing. Start in the done cycle is accepted (busy is already 0).
- Snapshot isolation: changes on params_in after start never affect the frame in flight.
- abort=1 in SEND/CSUM: next cycle state=IDLE, out_valid=0, out_last=0, busy=0, done=0; the partial frame is discarded. Abort has priority over a coincident handshake. Abort in IDLE has no effect. abort and start in the same IDLE cycle: abort wins, start is ignored.
- out_ready while out_valid=0 is ignored.
- Asserting reset mid-frame clears everything immediately (asynchronous), with no done pulse.
- Throughput: 1 byte/cycle with out_ready held high. A frame takes NBYTES(+1) cycles plus 1 start cycle.

Decomposition:
- Shared package nn_param_pkg holds:
  - constants NUM_NEURONS, PARAMS_PER_NEURON, PARAM_W, NBYTES;
  - the byte-offset constants OFF_W0..OFF_W3, OFF_B, OFF_TH, so this block and the loader agree on ordering;
  - the state enum {IDLE, SEND, CSUM}.
- No sub-module is required. The snapshot mux plus FSM form a single module of about 150-250 lines.

Test Plan:
- Basic frame: params byte k = k+1 (0x01..0x18), CHECKSUM_EN=1, out_ready=1, pulse start. Expect 25 bytes 0x01..0x18 then 0x18 (XOR of 1..24). out_last only on byte 25. done 1 cycle later. busy high for exactly 25 cycles.
- Backpressure: same data, out_ready toggling 1,0,0,1 repeatedly. Expect the identical byte sequence, out_data stable while valid && !ready, and no byte dropped or duplicated.
- Snapshot isolation: start, then change params_in to all 0xFF on the next cycle. Expect the original 0x01..0x18 stream and checksum 0x18.
- Abort: abort after the 5th handshake (byte 0x05 accepted). Expect out_valid=0 and busy=0 the next cycle, no done. A new start then sends from 0x01.
- Ignored start / CHECKSUM_EN=0: start held high through the whole frame. Expect only one frame of 24 bytes, out_last on th3 (0x18), done once. A start in the done cycle begins a second frame.
- Async reset mid-frame: drop reset at byte 10 with no clock edge. Expect all outputs 0 immediately and IDLE after release.
